// File: rtl/reg_scoreboard_pkg.sv
// Shared opcode and register-file definitions for the ID-stage scoreboard.
// Everything that sizes the register file or names an instruction class lives
// here so the scoreboard and its neighbours agree on one set of numbers.
package reg_scoreboard_pkg;

    localparam int SB_NUM_REG = 4;
    localparam int REG_AW     = 2;
    localparam int WORD_W     = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    // Largest value a pending counter of the given width may hold.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / retire / hazard signals between the ID and WB stages and the
// scoreboard. The pipeline side uses the master modport, the scoreboard the
// slave modport.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REG = SB_NUM_REG
);

    logic               issue_valid;
    logic               issue_dest_valid;
    reg_addr_t          issue_dest;
    logic               src1_valid;
    logic               src2_valid;
    reg_addr_t          src1;
    reg_addr_t          src2;
    logic               wb_valid;
    reg_addr_t          wb_addr;
    logic               squash_valid;
    reg_addr_t          squash_addr;
    logic               stall;
    logic [NUM_REG-1:0] pending_mask;
    logic               sb_error;

    modport master (
        output issue_valid, issue_dest_valid, issue_dest,
        output src1_valid, src2_valid, src1, src2,
        output wb_valid, wb_addr, squash_valid, squash_addr,
        input  stall, pending_mask, sb_error
    );

    modport slave (
        input  issue_valid, issue_dest_valid, issue_dest,
        input  src1_valid, src2_valid, src1, src2,
        input  wb_valid, wb_addr, squash_valid, squash_addr,
        output stall, pending_mask, sb_error
    );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One pending-writer counter for a single architectural register.
// Counts up on an accepted issue, down on each retire (write-back and/or
// squash), never drops below zero and flags any retire it cannot absorb.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_sq,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             underflow
);

    localparam logic [CNT_W:0] WIDE_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W:0]   grown;
    logic [CNT_W:0]   shrink;
    logic [CNT_W:0]   next_wide;
    logic [CNT_W-1:0] next_count;

    // Net change for this cycle: issue and retire cancel, a double retire
    // removes two, and anything that would go below zero floors at zero.
    always_comb begin
        grown      = {1'b0, count} + {{CNT_W{1'b0}}, inc};
        shrink     = {{CNT_W{1'b0}}, dec_wb} + {{CNT_W{1'b0}}, dec_sq};
        underflow  = 1'b0;
        next_wide  = '0;
        if (grown < shrink) begin
            underflow = 1'b1;
        end else begin
            next_wide = grown - shrink;
        end
        if (next_wide > WIDE_MAX) begin
            next_count = WIDE_MAX[CNT_W-1:0];
        end else begin
            next_count = next_wide[CNT_W-1:0];
        end
    end

    // Counter and its nonzero flag are both flops so the pending mask has no
    // combinational path from the pipeline inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= next_count;
            busy  <= (next_count != '0);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage: tracks in-flight writers per register
// and raises a combinational stall on RAW hazards or a saturated counter.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a source whose only pending
// writer is writing back this very cycle proceed without stalling.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REG = SB_NUM_REG,
    parameter int CNT_W   = SB_CNT_W
)(
    input  logic                   clk,
    input  logic                   reset_n,
    reg_scoreboard_if.slave        sb
);

    localparam logic [CNT_W-1:0] CNT_FULL = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]   count [NUM_REG];
    logic [NUM_REG-1:0] inc;
    logic [NUM_REG-1:0] dec_wb;
    logic [NUM_REG-1:0] dec_sq;
    logic [NUM_REG-1:0] busy;
    logic [NUM_REG-1:0] underflow;
    logic               src1_hazard;
    logic               src2_hazard;
    logic               dest_full;
    logic               issue_accept;

    // Hazard detection: a read of a register with pending writers must wait,
    // and an issue may not push its destination counter past saturation.
    always_comb begin
        src1_hazard = sb.src1_valid && (count[sb.src1] != '0);
        src2_hazard = sb.src2_valid && (count[sb.src2] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (sb.wb_valid && (sb.wb_addr == sb.src1) && (count[sb.src1] == CNT_ONE)) begin
            src1_hazard = 1'b0;
        end
        if (sb.wb_valid && (sb.wb_addr == sb.src2) && (count[sb.src2] == CNT_ONE)) begin
            src2_hazard = 1'b0;
        end
`endif
        dest_full    = sb.issue_dest_valid && (count[sb.issue_dest] == CNT_FULL);
        sb.stall     = reset_n && (src1_hazard || src2_hazard || dest_full);
        issue_accept = sb.issue_valid && sb.issue_dest_valid && !sb.stall;
    end

    // Steer the accepted issue and the two retire ports to one counter each.
    always_comb begin
        inc    = '0;
        dec_wb = '0;
        dec_sq = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            inc[r]    = issue_accept    && (sb.issue_dest  == REG_AW'(r));
            dec_wb[r] = sb.wb_valid     && (sb.wb_addr     == REG_AW'(r));
            dec_sq[r] = sb.squash_valid && (sb.squash_addr == REG_AW'(r));
        end
    end

    for (genvar r = 0; r < NUM_REG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc[r]),
            .dec_wb    (dec_wb[r]),
            .dec_sq    (dec_sq[r]),
            .count     (count[r]),
            .busy      (busy[r]),
            .underflow (underflow[r])
        );
    end

    // The per-counter busy flops already form the registered pending mask.
    always_comb begin
        sb.pending_mask = busy;
    end

    // Sticky error: any retire that found nothing to retire is remembered
    // until the next reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb.sb_error <= 1'b0;
        end else if (|underflow) begin
            sb.sb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard cases followed by
// randomized traffic, all compared against a counter-array reference model.
// Honours SCOREBOARD_WB_BYPASS_EN the same way the design does.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int NREG      = 4;
    localparam int CNT_LIMIT = 3;

    logic clk;
    logic reset_n;

    int errors;
    int checks;
    int cnt [NREG];
    bit mod_err;
    logic seen_stall;

    reg_scoreboard_if #(.NUM_REG(NREG)) sb_if ();

    reg_scoreboard #(
        .NUM_REG (NREG),
        .CNT_W   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A source blocks unless nothing is pending, or (with bypass) its single
    // pending writer is the one writing back right now.
    function automatic bit srcBlocked(input int a, input bit wv, input int wa);
        if (cnt[a] == 0) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (cnt[a] == 1 && wv && wa == a) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit modelStall(input bit rn, input bit idv, input int id,
                                      input bit s1v, input int a1, input bit s2v, input int a2,
                                      input bit wv, input int wa);
        if (!rn) return 1'b0;
        if (idv && cnt[id] == CNT_LIMIT) return 1'b1;
        if (s1v && srcBlocked(a1, wv, wa)) return 1'b1;
        if (s2v && srcBlocked(a2, wv, wa)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelMask();
        logic [31:0] m = '0;
        for (int r = 0; r < NREG; r++) if (cnt[r] != 0) m[r] = 1'b1;
        return m;
    endfunction

    function automatic int pickPending();
        int q[$];
        for (int r = 0; r < NREG; r++) if (cnt[r] != 0) q.push_back(r);
        if (q.size() == 0) return $urandom_range(0, NREG - 1);
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    // Drive one cycle of inputs, check stall mid-cycle, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic applyStimulus(input bit rn, input bit iv, input bit idv, input int id,
                                 input bit s1v, input int a1, input bit s2v, input int a2,
                                 input bit wv, input int wa, input bit qv, input int qa);
        bit exp_stall;
        bit acc;
        int c;
        reset_n                = rn;
        sb_if.issue_valid      = iv;
        sb_if.issue_dest_valid = idv;
        sb_if.issue_dest       = REG_AW'(id);
        sb_if.src1_valid       = s1v;
        sb_if.src1             = REG_AW'(a1);
        sb_if.src2_valid       = s2v;
        sb_if.src2             = REG_AW'(a2);
        sb_if.wb_valid         = wv;
        sb_if.wb_addr          = REG_AW'(wa);
        sb_if.squash_valid     = qv;
        sb_if.squash_addr      = REG_AW'(qa);
        #2;
        exp_stall  = modelStall(rn, idv, id, s1v, a1, s2v, a2, wv, wa);
        seen_stall = sb_if.stall;
        checkOutput("stall", 32'(sb_if.stall), 32'(exp_stall));
        @(posedge clk);
        if (!rn) begin
            for (int r = 0; r < NREG; r++) cnt[r] = 0;
            mod_err = 1'b0;
        end else begin
            acc = iv && idv && !exp_stall;
            for (int r = 0; r < NREG; r++) begin
                c = cnt[r] + int'(acc && id == r) - int'(wv && wa == r) - int'(qv && qa == r);
                if (c < 0) begin
                    c = 0;
                    mod_err = 1'b1;
                end
                cnt[r] = c;
            end
        end
        #1;
        checkOutput("pending_mask", 32'(sb_if.pending_mask), modelMask());
        checkOutput("sb_error", 32'(sb_if.sb_error), 32'(mod_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        mod_err = 1'b0;
        for (int r = 0; r < NREG; r++) cnt[r] = 0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_mask", 32'(sb_if.pending_mask), 32'h0);
        checkOutput("reset_err", 32'(sb_if.sb_error), 32'h0);

        // Issue R1, then read R1: stall; write back R1: clear
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_mask_set", 32'(sb_if.pending_mask), 32'b0010);
        applyStimulus(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_stall", 32'(seen_stall), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("raw_mask_clr", 32'(sb_if.pending_mask), 32'b0000);
        applyStimulus(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_nostall", 32'(seen_stall), 32'h0);

        // Saturate R2, fourth issue stalls, three write-backs drain it
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_stall", 32'(seen_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
            checkOutput("sat_drain", 32'(sb_if.pending_mask[2]), (i < 2) ? 32'h1 : 32'h0);
        end
        checkOutput("sat_err", 32'(sb_if.sb_error), 32'h0);

        // Same-cycle write-back of the only pending writer of src2
        applyStimulus(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        checkOutput("bypass_stall", 32'(seen_stall), 32'h0);
`else
        checkOutput("bypass_stall", 32'(seen_stall), 32'h1);
`endif

        // Issue and write-back of R0 in the same cycle cancel out
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("cancel_mask", 32'(sb_if.pending_mask[0]), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("cancel_drain", 32'(sb_if.pending_mask), 32'h0);

        // Squash of an idle register raises a sticky error
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("squash_err", 32'(sb_if.sb_error), 32'h1);
        checkOutput("squash_floor", 32'(sb_if.pending_mask), 32'h0);
        idle(3);
        checkOutput("err_sticky", 32'(sb_if.sb_error), 32'h1);

        // Reset mid-operation with an issue presented
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_stall", 32'(seen_stall), 32'h0);
        checkOutput("rst_mask", 32'(sb_if.pending_mask), 32'h0);
        checkOutput("rst_err", 32'(sb_if.sb_error), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit rn = ($urandom_range(0, 39) != 0);
            bit iv = ($urandom_range(0, 9) < 6);
            bit idv = ($urandom_range(0, 9) < 8);
            int id = $urandom_range(0, NREG - 1);
            bit s1v = $urandom_range(0, 1);
            int a1 = $urandom_range(0, NREG - 1);
            bit s2v = $urandom_range(0, 1);
            int a2 = $urandom_range(0, NREG - 1);
            bit wv = ($urandom_range(0, 9) < 4);
            int wa = pickPending();
            bit qv = ($urandom_range(0, 9) == 0);
            int qa = pickPending();
            applyStimulus(rn, iv, idv, id, s1v, a1, s2v, a2, wv, wa, qv, qa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
